// File: rtl/mult_check_pkg.sv
// Shared types and width helpers for the multiplier vector checker.
package mult_check_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Widths for the default two-bit operand build.
  localparam int DEF_WIDTH = 2;
  localparam int CNT_W     = 2 * DEF_WIDTH;
  localparam int ERR_W     = 2 * DEF_WIDTH + 1;

  // The same rules for a parameterised operand width.
  function automatic int cnt_w(input int width);
    return 2 * width;
  endfunction

  // One extra bit so a sweep where every vector fails still fits.
  function automatic int err_w(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/mult_vector_checker_if.sv
// Result-record stream from the checker to a downstream logger.
interface mult_vector_checker_if #(
  parameter int WIDTH = 2
);
  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     res_a;
  logic [WIDTH-1:0]     res_b;
  logic [2*WIDTH-1:0]   res_p;
  logic                 res_ok;

  modport master (
    output res_valid, res_a, res_b, res_p, res_ok,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_a, res_b, res_p, res_ok,
    output res_ready
  );
endinterface

// File: rtl/mult_golden_ref.sv
// Golden full-width product; kept standalone so other checker stages can share it.
module mult_golden_ref #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  localparam int PW = 2 * WIDTH;

  // Widen both operands before multiplying so no product bits are lost.
  assign p = PW'(a) * PW'(b);
endmodule

// File: rtl/mult_vector_checker.sv
// Exhaustive operand sweep around a combinational multiplier with result streaming.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// DRIVE  | operands applied, waiting SETTLE cycles for the product
// SAMPLE | capture product, compare to golden, update error tally
// EMIT   | result record offered downstream until accepted
// DONE   | sweep complete, summary held until the next start
module mult_vector_checker
  import mult_check_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [2*WIDTH-1:0]   dut_p,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [WIDTH-1:0]     first_fail_b,
  output logic [2*WIDTH-1:0]   first_fail_p,
  mult_vector_checker_if.master res
);

  localparam int CW    = cnt_w(WIDTH);
  localparam int EW    = err_w(WIDTH);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic               settle_tc;
  logic               start_ok;
  logic               last_vec;
  logic               mismatch;
  logic [CW-1:0]      golden;
  logic [EW-1:0]      err_cnt;
  logic [WIDTH-1:0]   ff_a, ff_b;
  logic [CW-1:0]      ff_p;
  logic [WIDTH-1:0]   rec_a, rec_b;
  logic [CW-1:0]      rec_p;
  logic               rec_ok;
  logic               rec_valid;

  assign {dut_a, dut_b} = cnt;

  mult_golden_ref #(.WIDTH(WIDTH)) u_golden (
    .a (dut_a),
    .b (dut_b),
    .p (golden)
  );

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign settle_tc = (settle_cnt == SET_W'(SETTLE - 1));
  assign last_vec  = &cnt;
  assign mismatch  = (dut_p != golden);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = DRIVE;
      DRIVE:   if (settle_tc) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = EMIT;
      EMIT:    if (res.res_ready) state_nxt = last_vec ? DONE : DRIVE;
      DONE:    if (start_ok) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded status outputs; res_valid depends only on state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    rec_valid = 1'b0;
    unique case (state)
      DRIVE, SAMPLE: busy = 1'b1;
      EMIT: begin
        busy      = 1'b1;
        rec_valid = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_cnt == '0);
      end
      default: ;
    endcase
  end

  // Vector index, settle timer, error tally and captured records.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_p       <= '0;
      rec_a      <= '0;
      rec_b      <= '0;
      rec_p      <= '0;
      rec_ok     <= 1'b0;
    end else if (start_ok) begin
      cnt        <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_p       <= '0;
    end else begin
      unique case (state)
        DRIVE: settle_cnt <= settle_tc ? '0 : settle_cnt + SET_W'(1);
        SAMPLE: begin
          rec_a  <= dut_a;
          rec_b  <= dut_b;
          rec_p  <= dut_p;
          rec_ok <= !mismatch;
          if (mismatch) begin
            err_cnt <= err_cnt + EW'(1);
            if (err_cnt == '0) begin
              ff_a <= dut_a;
              ff_b <= dut_b;
              ff_p <= dut_p;
            end
          end
        end
        EMIT: if (res.res_ready && !last_vec) cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

  assign err_count     = err_cnt;
  assign first_fail_a  = ff_a;
  assign first_fail_b  = ff_b;
  assign first_fail_p  = ff_p;
  assign res.res_valid = rec_valid;
  assign res.res_a     = rec_a;
  assign res.res_b     = rec_b;
  assign res.res_p     = rec_p;
  assign res.res_ok    = rec_ok;

endmodule

// File: tb/tb_mult_vector_checker.sv
// Randomised sweep bench for mult_vector_checker with behavioural multiplier models.
module tb_mult_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, ready, sel;
  int   mode;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [1:0] a1, b1, a3, b3, ffa1, ffb1, ffa3, ffb3;
  logic [3:0] p1, p3, ffp1, ffp3;
  logic [4:0] err1, err3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [3:0] ab1_d1, ab1_d2, ab3_d1, ab3_d2;

  mult_vector_checker_if #(.WIDTH(2)) rif1 ();
  mult_vector_checker_if #(.WIDTH(2)) rif3 ();
  assign rif1.res_ready = ready;
  assign rif3.res_ready = ready;

  mult_vector_checker #(.WIDTH(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel),
    .dut_a(a1), .dut_b(b1), .dut_p(p1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_p(ffp1),
    .res(rif1)
  );

  mult_vector_checker #(.WIDTH(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start & sel),
    .dut_a(a3), .dut_b(b3), .dut_p(p3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_a(ffa3), .first_fail_b(ffb3), .first_fail_p(ffp3),
    .res(rif3)
  );

  function automatic logic [3:0] mul4(input logic [1:0] a, input logic [1:0] b);
    return {2'b00, a} * {2'b00, b};
  endfunction

  // Multiplier under test: mode 0 correct, 1 with P[0] stuck low, 2 lagging inputs by two cycles.
  always @(posedge clk) begin
    ab1_d1 <= {a1, b1};
    ab1_d2 <= ab1_d1;
    ab3_d1 <= {a3, b3};
    ab3_d2 <= ab3_d1;
  end

  always_comb begin
    p1 = mul4(a1, b1);
    p3 = mul4(a3, b3);
    if (mode == 1) begin
      p1 = mul4(a1, b1) & 4'he;
      p3 = mul4(a3, b3) & 4'he;
    end else if (mode == 2) begin
      p1 = mul4(ab1_d2[3:2], ab1_d2[1:0]);
      p3 = mul4(ab3_d2[3:2], ab3_d2[1:0]);
    end
  end

  logic       o_valid, o_ok, o_busy, o_done, o_pass;
  logic [1:0] o_a, o_b, o_ffa, o_ffb;
  logic [3:0] o_p, o_ffp;
  logic [4:0] o_err;

  always_comb begin
    if (sel) begin
      o_valid = rif3.res_valid; o_a = rif3.res_a; o_b = rif3.res_b;
      o_p = rif3.res_p; o_ok = rif3.res_ok; o_busy = busy3; o_done = done3;
      o_pass = pass3; o_err = err3; o_ffa = ffa3; o_ffb = ffb3; o_ffp = ffp3;
    end else begin
      o_valid = rif1.res_valid; o_a = rif1.res_a; o_b = rif1.res_b;
      o_p = rif1.res_p; o_ok = rif1.res_ok; o_busy = busy1; o_done = done1;
      o_pass = pass1; o_err = err1; o_ffa = ffa1; o_ffb = ffb1; o_ffp = ffp1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // rmode: 0 ready always high, 1 random ready plus start pulses while busy, 2 five-cycle stall on record (2,3).
  task automatic run_sweep(input bit use3, input int m, input int rmode, input bit exact);
    int         s, cycles, stalls, k, stall_k, exp_err;
    logic [1:0] ffa_e, ffb_e, ea, eb;
    logic [3:0] ffp_e, tp, ep;
    logic [9:0] held;
    bit         hold;
    sel = use3;
    mode = m;
    s = use3 ? 3 : 1;
    exp_err = 0;
    ffa_e = '0; ffb_e = '0; ffp_e = '0;
    for (int i = 0; i < 16; i++) begin
      tp = mul4(2'(i >> 2), 2'(i));
      ep = (m == 1) ? (tp & 4'he) : tp;
      if (ep != tp) begin
        if (exp_err == 0) begin
          ffa_e = 2'(i >> 2); ffb_e = 2'(i); ffp_e = ep;
        end
        exp_err++;
      end
    end

    ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 32'(o_busy), 32'd1);
    check("done_after_start", 32'(o_done), 32'd0);

    cycles = 0; stalls = 0; k = 0; stall_k = 0; hold = 0; held = '0;
    while (cycles < 1000) begin
      @(negedge clk);
      if (o_done) break;
      start = 1'b0;
      if (o_valid) begin
        if (hold) check("record_hold", 32'({o_a, o_b, o_p, o_ok}), 32'(held));
        else begin
          held = {o_a, o_b, o_p, o_ok};
          hold = 1;
        end
        case (rmode)
          0:       ready = 1'b1;
          1:       ready = ($urandom_range(0, 2) != 0);
          default: ready = !((k == 11) && (stall_k < 5));
        endcase
        if (ready) begin
          ea = 2'(k >> 2);
          eb = 2'(k);
          tp = mul4(ea, eb);
          ep = (m == 1) ? (tp & 4'he) : tp;
          if (exact)
            check("record", 32'({o_a, o_b, o_p, o_ok}), 32'({ea, eb, ep, ep == tp}));
          else
            check("record_ab_ok", 32'({o_a, o_b, o_ok}), 32'({ea, eb, o_p == mul4(o_a, o_b)}));
          k++;
          hold = 0;
        end else begin
          stalls++;
          if (k == 11) stall_k++;
        end
      end else begin
        ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rmode == 1 && $urandom_range(0, 3) == 0) start = 1'b1;
      end
      @(posedge clk);
      cycles++;
    end
    start = 1'b0;
    ready = 1'b1;

    check("sweep_done", 32'(o_done), 32'd1);
    check("record_count", 32'(k), 32'd16);
    check("done_latency", 32'(cycles), 32'(16 * (s + 2) + stalls));
    check("busy_in_done", 32'(o_busy), 32'd0);
    if (exact) begin
      check("err_count", 32'(o_err), 32'(exp_err));
      check("pass", 32'(o_pass), 32'(exp_err == 0));
      check("first_fail", 32'({o_ffa, o_ffb, o_ffp}), 32'({ffa_e, ffb_e, ffp_e}));
    end else begin
      check("lag_err_nonzero", 32'(o_err != 0), 32'd1);
      check("lag_pass", 32'(o_pass), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 1'b0; mode = 0;
    #12;
    check("reset_outputs_s1", 32'({a1, b1, busy1, done1, pass1, err1, ffa1, ffb1, ffp1,
          rif1.res_valid, rif1.res_a, rif1.res_b, rif1.res_p, rif1.res_ok}), 32'd0);
    check("reset_outputs_s3", 32'({a3, b3, busy3, done3, pass3, err3, ffa3, ffb3, ffp3,
          rif3.res_valid, rif3.res_a, rif3.res_b, rif3.res_p, rif3.res_ok}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(1'b0, 0, 0, 1'b1);
    run_sweep(1'b0, 1, 0, 1'b1);
    run_sweep(1'b0, 0, 2, 1'b1);
    run_sweep(1'b0, 0, 1, 1'b1);
    run_sweep(1'b1, 2, 1, 1'b1);
    run_sweep(1'b0, 2, 0, 1'b0);

    // Abort a sweep while vector 7 (a=1, b=3) is on the operands.
    sel = 1'b0; mode = 0; ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy1 && a1 == 2'd1 && b1 == 2'd3) break;
    end
    check("reached_vector7", 32'({busy1, a1, b1}), 32'({1'b1, 2'd1, 2'd3}));
    #2 rst_n = 1'b0;
    #1;
    check("midsweep_reset", 32'({a1, b1, busy1, done1, pass1, err1, ffa1, ffb1, ffp1,
          rif1.res_valid, rif1.res_a, rif1.res_b, rif1.res_p, rif1.res_ok}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b0, 1, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
